// File: rtl/memory_driver_pkg.sv
// Shared definitions for the buffer-RAM write and read drivers:
// geometry constants, FSM state encodings and the word-count clamp.
package memory_driver_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = ADDR_W + 1;

  // Largest transfer length; CNT_W bits so that a full buffer is representable.
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
    return (n > MAX_WORDS) ? MAX_WORDS : n;
  endfunction

endpackage

// File: rtl/memory_reader_driver.sv
// Drains the shared 64x32 buffer RAM from address 0 and streams the words
// on a valid/ready port, one RAM read per accepted word, then pulses done.
module memory_reader_driver
  import memory_driver_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  state_e            state_q;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  remaining_q;

  // Every output is a register loaded on the transition into the state that
  // owns it, so outputs line up with the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      mem_rd_en_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (word_count == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              remaining_q <= clamp_count(word_count);
              mem_addr_q  <= '0;
              mem_rd_en_q <= 1'b1;
              state_q     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          out_data_q  <= mem_rd_data;
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          // While stalled nothing moves: no RAM access, data held.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              mem_addr_q  <= mem_addr_q + ADDR_W'(1);
              mem_rd_en_q <= 1'b1;
              state_q     <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_memory_reader_driver.sv
// Self-checking bench for memory_reader_driver: table of readouts plus random
// runs, each judged against the RAM contents and simple cycle arithmetic.
module tb_memory_reader_driver;
  import memory_driver_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  word_count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [2:0]        state;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  typedef struct {
    int wc;
    int stall_pct;
    int stall0;
    int restart_word;
    int exp_n;
    int exp_done;
  } vec_t;

  vec_t vecs [8];

  memory_reader_driver dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sync_ram_64x32: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) ram_rd_q <= ram[mem_addr];
  end
  assign mem_rd_data = ram_rd_q;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  function automatic int expected_words(input int wc);
    return (wc > DEPTH) ? DEPTH : wc;
  endfunction

  task automatic run(input int wc, input int stall_pct, input int stall0,
                     input int restart_word, input int exp_n, input int exp_done);
    int cyc, got, reads, vcycles, done_cyc, first_valid, first_rd, stall_left;
    int rd_bad, stall_rd, hold_bad, busy_bad, data_bad;
    bit restarted, prev_stall;
    logic [DATA_W-1:0] prev_data;
    got = 0; reads = 0; vcycles = 0; done_cyc = -1; first_valid = -1; first_rd = -1;
    rd_bad = 0; stall_rd = 0; hold_bad = 0; busy_bad = 0; data_bad = 0;
    restarted = 1'b0; prev_stall = 1'b0; prev_data = '0; stall_left = stall0;

    @(negedge clk);
    chk("idle_state", int'(state), int'(ST_IDLE));
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_valid", int'(out_valid), 0);
    start = 1'b1;
    word_count = CNT_W'(wc);
    @(negedge clk);
    word_count = CNT_W'($urandom);
    cyc = 1;
    forever begin
      start = 1'b0;
      if (mem_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (mem_addr !== ADDR_W'(reads)) rd_bad++;
        if (out_valid) stall_rd++;
        reads++;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) hold_bad++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (out_valid) begin
        vcycles++;
        if (first_valid < 0) first_valid = cyc;
        if (!restarted && restart_word >= 0 && got == restart_word) begin
          start = 1'b1;
          word_count = CNT_W'(5);
          restarted = 1'b1;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = (int'($urandom_range(99)) >= stall_pct);
        end
        if (out_ready) begin
          if (got >= DEPTH || out_data !== ram[got]) data_bad++;
          got++;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (cyc >= 2000) break;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;

    chk("done_seen", int'(done_cyc > 0), 1);
    chk("words", got, exp_n);
    chk("reads", reads, exp_n);
    chk("rd_addr_errs", rd_bad, 0);
    chk("data_errs", data_bad, 0);
    chk("rd_during_valid", stall_rd, 0);
    chk("hold_errs", hold_bad, 0);
    chk("busy_errs", busy_bad, 0);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    if (exp_n > 0) chk("first_rd_cycle", first_rd, 1);
    if (exp_n > 0 && stall_pct == 0 && stall0 == 0) begin
      chk("first_valid_cycle", first_valid, 3);
      chk("valid_cycles", vcycles, exp_n);
    end
    if (exp_n == 0) chk("zero_valid", vcycles, 0);
    $display("run wc=%0d stall=%0d%% words=%0d done_cycle=%0d", wc, stall_pct, got, done_cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_count = '0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;

    vecs[0] = '{wc: 4,   stall_pct: 0,  stall0: 0, restart_word: -1, exp_n: 4,  exp_done: 13};
    vecs[1] = '{wc: 2,   stall_pct: 0,  stall0: 5, restart_word: -1, exp_n: 2,  exp_done: 12};
    vecs[2] = '{wc: 0,   stall_pct: 0,  stall0: 0, restart_word: -1, exp_n: 0,  exp_done: 1};
    vecs[3] = '{wc: 100, stall_pct: 0,  stall0: 0, restart_word: -1, exp_n: 64, exp_done: 193};
    vecs[4] = '{wc: 3,   stall_pct: 0,  stall0: 0, restart_word: 1,  exp_n: 3,  exp_done: 10};
    vecs[5] = '{wc: 1,   stall_pct: 0,  stall0: 0, restart_word: -1, exp_n: 1,  exp_done: 4};
    vecs[6] = '{wc: 64,  stall_pct: 0,  stall0: 0, restart_word: -1, exp_n: 64, exp_done: 193};
    vecs[7] = '{wc: 127, stall_pct: 20, stall0: 0, restart_word: -1, exp_n: 64, exp_done: -1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", int'(state), int'(ST_IDLE));
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // Runs follow each other directly, so each start lands the cycle after done.
    for (int v = 0; v < 8; v++)
      run(vecs[v].wc, vecs[v].stall_pct, vecs[v].stall0, vecs[v].restart_word,
          vecs[v].exp_n, vecs[v].exp_done);

    // Abort in the WAIT cycle of word 2 of 8.
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1; word_count = CNT_W'(8);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_state", int'(state), int'(ST_WAIT));
    chk("pre_rst_addr", int'(mem_addr), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", int'(state), int'(ST_IDLE));
    chk("abort_rd_en", int'(mem_rd_en), 0);
    chk("abort_addr", int'(mem_addr), 0);
    chk("abort_data", int'(out_data), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    $display("abort wc=8 at word 2 state=%0d busy=%0d", state, busy);
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_done", int'(done), 0);
    end
    run(3, 0, 0, -1, 3, 10);

    for (int r = 0; r < 16; r++) begin
      int wc, sp, n;
      wc = int'($urandom_range(127));
      sp = (r % 3 == 0) ? 0 : int'($urandom_range(60));
      n  = expected_words(wc);
      run(wc, sp, 0, -1, n, (sp == 0) ? 3 * n + 1 : -1);
    end

    @(negedge clk);
    chk("final_state", int'(state), int'(ST_IDLE));
    chk("final_done", int'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
